// File: rtl/norm_seq_ctrl.sv
// Post-mantissa normalisation sequencer: chunked leading-one scan, then normal/denormal shift.
// Optional `define NORM_STICKY_EN adds out_sticky (OR of the bits shifted below the fraction).
module norm_seq_ctrl #(
  parameter int unsigned CHUNK = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [49:0] in_mant,
  input  logic [7:0]  in_exp,
  input  logic        in_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [21:0] out_mant,
  output logic [7:0]  out_exp,
  output logic        out_sign,
  output logic        out_zero,
`ifdef NORM_STICKY_EN
  output logic        out_sticky,
`endif
  output logic        out_ovf
);

  localparam int unsigned NCH = (50 + CHUNK - 1) / CHUNK;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [49:0] mant_q;
  logic [7:0]  exp_q;
  logic [5:0]  cnt_q;
  logic [5:0]  lead_q;

  logic        hit;
  logic [5:0]  hit_pos;
  logic        last_chunk;
  int unsigned base, win_hi, win_lo;

  logic [8:0]  norm, e1, shamt, exp_res;
  logic [49:0] shifted;
  logic [21:0] frac;
  logic        ovf;

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);

  // Window for chunk c spans [49-c*CHUNK : max(0, 49-(c+1)*CHUNK+1)]; ascending loop keeps the highest hit.
  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    base    = 32'(cnt_q) * CHUNK;
    win_hi  = (base <= 32'd49) ? 32'd49 - base : 32'd0;
    win_lo  = (win_hi + 1 >= CHUNK) ? win_hi + 1 - CHUNK : 32'd0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (i <= win_hi && i >= win_lo && mant_q[i]) begin
        hit     = 1'b1;
        hit_pos = 6'(i);
      end
    end
    last_chunk = (32'(cnt_q) == NCH - 1);
  end

  always_comb begin
    norm = 9'd49 - {3'b000, lead_q};
    e1   = {1'b0, exp_q} + 9'd1;
    if (e1 < norm) begin
      shamt   = {1'b0, exp_q} + 9'd2;
      exp_res = '0;
    end else begin
      shamt   = norm + 9'd1;
      exp_res = e1 - norm;
    end
    shifted = mant_q << shamt;
    frac    = 22'(shifted >> 28);
    ovf     = (exp_res >= 9'd255);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = SCAN;
      SCAN:  if (hit) state_d = SHIFT;
             else if (last_chunk) state_d = DONE;
      SHIFT: state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_q     <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
      lead_q     <= '0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_sign   <= 1'b0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
`ifdef NORM_STICKY_EN
      out_sticky <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          mant_q     <= in_mant;
          exp_q      <= in_exp;
          out_sign   <= in_sign;
          cnt_q      <= '0;
          lead_q     <= '0;
          out_mant   <= '0;
          out_exp    <= '0;
          out_zero   <= 1'b0;
          out_ovf    <= 1'b0;
`ifdef NORM_STICKY_EN
          out_sticky <= 1'b0;
`endif
        end
        SCAN: begin
          if (hit) begin
            lead_q <= hit_pos;
          end else if (last_chunk) begin
            out_zero <= 1'b1;
            out_mant <= '0;
            out_exp  <= '0;
            out_ovf  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        SHIFT: begin
          if (ovf) begin
            out_ovf    <= 1'b1;
            out_exp    <= '1;
            out_mant   <= '0;
`ifdef NORM_STICKY_EN
            out_sticky <= 1'b0;
`endif
          end else begin
            out_mant   <= frac;
            out_exp    <= exp_res[7:0];
`ifdef NORM_STICKY_EN
            out_sticky <= |shifted[27:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
